// File: rtl/multi_operand_adder_pipe_if.sv
// Handshake bundle for the multi-operand adder pipeline.
// Master drives operands and result ready; slave is the adder.
interface multi_operand_adder_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_sum;
  logic                    out_ovf;
  logic                    ovf_clr;
  logic [CNT_W-1:0]        ovf_count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    output ovf_clr,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf,
    input  ovf_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    input  ovf_clr,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf,
    output ovf_count
  );
endinterface

// File: rtl/multi_operand_adder_pipe.sv
// Two-stage elastic N-operand signed adder with wrap/saturate
// result, overflow flag and a saturating overflow event counter.
module multi_operand_adder_pipe #(
  parameter int WIDTH    = 32,
  parameter int NUM_IN   = 3,
  parameter int SAT_MODE = 0,
  parameter int CNT_W    = 16
) (
  input logic ap_clk,
  input logic ap_rst,
  multi_operand_adder_pipe_if.slave bus
);
  localparam int SW  = WIDTH + $clog2(NUM_IN);
  localparam int NLO = (NUM_IN + 1) / 2;

  logic [SW-1:0]    p0_d, p1_d;
  logic [SW-1:0]    p0_q, p1_q;
  logic [SW-1:0]    t;
  logic [SW-WIDTH:0] top;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             ovf_d, ovf_q;
  logic             s1_valid_q, s2_valid_q;
  logic             s1_en, s2_en;
  logic             in_fire, out_fire;
  logic [CNT_W-1:0] cnt_q;

  assign s2_en    = !s2_valid_q || bus.out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = s2_valid_q && bus.out_ready;

  assign bus.in_ready  = s1_en && !ap_rst;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.ovf_count = cnt_q;

  // Sign-extend to SW bits so the partial sums are exact.
  always_comb begin
    p0_d = '0;
    p1_d = '0;
    op   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      op = bus.in_data[k*WIDTH +: WIDTH];
      if (k < NLO)
        p0_d = p0_d + {{(SW-WIDTH){op[WIDTH-1]}}, op};
      else
        p1_d = p1_d + {{(SW-WIDTH){op[WIDTH-1]}}, op};
    end
  end

  // In range iff all bits from WIDTH-1 upward agree.
  always_comb begin
    t     = p0_q + p1_q;
    top   = t[SW-1:WIDTH-1];
    ovf_d = !((&top) || !(|top));
    sum_d = t[WIDTH-1:0];
    if (SAT_MODE != 0 && ovf_d) begin
      if (t[SW-1])
        sum_d = {1'b1, {(WIDTH-1){1'b0}}};
      else
        sum_d = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q <= 1'b0;
      p0_q       <= '0;
      p1_q       <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        p0_q <= p0_d;
        p1_q <= p1_d;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q <= sum_d;
        ovf_q <= ovf_d;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst || bus.ovf_clr)
      cnt_q <= '0;
    else if (out_fire && ovf_q && !(&cnt_q))
      cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_multi_operand_adder_pipe.sv
// Directed bench: wrap, saturate and 2-bit-counter instances
// driven in lockstep, table vectors plus handshake sequences.
module tb_multi_operand_adder_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_operand_adder_pipe_if #(.WIDTH(32), .NUM_IN(3), .CNT_W(16)) bw ();
  multi_operand_adder_pipe_if #(.WIDTH(32), .NUM_IN(3), .CNT_W(16)) bs ();
  multi_operand_adder_pipe_if #(.WIDTH(32), .NUM_IN(3), .CNT_W(2))  bc ();

  multi_operand_adder_pipe #(
    .WIDTH(32), .NUM_IN(3), .SAT_MODE(0), .CNT_W(16)
  ) dw (.ap_clk(clk), .ap_rst(rst), .bus(bw));
  multi_operand_adder_pipe #(
    .WIDTH(32), .NUM_IN(3), .SAT_MODE(1), .CNT_W(16)
  ) ds (.ap_clk(clk), .ap_rst(rst), .bus(bs));
  multi_operand_adder_pipe #(
    .WIDTH(32), .NUM_IN(3), .SAT_MODE(0), .CNT_W(2)
  ) dc (.ap_clk(clk), .ap_rst(rst), .bus(bc));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] ws;
    logic [31:0] ss;
    logic        ov;
  } vec_t;

  vec_t tv [8];
  int total = 0;
  int bad   = 0;
  int ecw   = 0;
  int ecc   = 0;
  logic [31:0] got [4];
  logic        gv  [4];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    bw.in_valid = v; bw.in_data = {c, b, a};
    bs.in_valid = v; bs.in_data = {c, b, a};
    bc.in_valid = v; bc.in_data = {c, b, a};
  endtask

  task automatic set_rdy(input logic r);
    bw.out_ready = r;
    bs.out_ready = r;
    bc.out_ready = r;
  endtask

  task automatic set_clr(input logic c);
    bw.ovf_clr = c;
    bs.ovf_clr = c;
    bc.ovf_clr = c;
  endtask

  task automatic chk_cnt(input string n);
    chk({n, "_cw"}, bw.ovf_count, ecw);
    chk({n, "_cs"}, bs.ovf_count, ecw);
    chk({n, "_cc"}, bc.ovf_count, ecc);
  endtask

  initial begin
    tv[0] = '{32'd1, 32'd2, 32'd3, 32'd6, 32'd6, 1'b0};
    tv[1] = '{32'h7FFFFFFF, 32'd1, 32'd0,
              32'h80000000, 32'h7FFFFFFF, 1'b1};
    tv[2] = '{32'h80000000, 32'h80000000, 32'h80000000,
              32'h80000000, 32'h80000000, 1'b1};
    tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
              32'd0, 32'd0, 1'b0};
    tv[4] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000,
              32'h7FFFFFFE, 32'h7FFFFFFE, 1'b0};
    tv[5] = '{32'h80000000, 32'hFFFFFFFF, 32'd1,
              32'h80000000, 32'h80000000, 1'b0};
    tv[6] = '{32'h80000000, 32'hFFFFFFFF, 32'd0,
              32'h7FFFFFFF, 32'h80000000, 1'b1};
    tv[7] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
              32'h7FFFFFFD, 32'h7FFFFFFF, 1'b1};

    set_in(1'b0, '0, '0, '0);
    set_rdy(1'b1);
    set_clr(1'b0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bw.out_valid, 0);
    chk("rst_in_ready", bw.in_ready, 1);
    chk("rst_out_sum", bw.out_sum, 0);
    chk("rst_out_ovf", bw.out_ovf, 0);
    chk_cnt("rst");

    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, tv[i].a, tv[i].b, tv[i].c);
      #1;
      chk($sformatf("v%0d_in_ready", i), bw.in_ready, 1);
      tick;
      set_in(1'b0, 'x, 'x, 'x);
      chk($sformatf("v%0d_lat1", i), bw.out_valid, 0);
      tick;
      chk($sformatf("v%0d_lat2", i), bw.out_valid, 1);
      chk($sformatf("v%0d_wsum", i), bw.out_sum, tv[i].ws);
      chk($sformatf("v%0d_ssum", i), bs.out_sum, tv[i].ss);
      chk($sformatf("v%0d_csum", i), bc.out_sum, tv[i].ws);
      chk($sformatf("v%0d_wovf", i), bw.out_ovf, tv[i].ov);
      chk($sformatf("v%0d_sovf", i), bs.out_ovf, tv[i].ov);
      tick;
      if (tv[i].ov) begin
        ecw++;
        if (ecc < 3) ecc++;
      end
      chk_cnt($sformatf("v%0d", i));
      chk($sformatf("v%0d_nodup", i), bw.out_valid, 0);
    end

    // Two more back-to-back overflows; 2-bit counter stays at 3.
    set_in(1'b1, 32'h7FFFFFFF, 32'd1, 32'd0);
    tick;
    tick;
    set_in(1'b0, 'x, 'x, 'x);
    tick;
    tick;
    ecw += 2;
    chk_cnt("sat_cnt");

    // Clear collides with an overflowing output transfer.
    set_in(1'b1, 32'h7FFFFFFF, 32'd1, 32'd0);
    tick;
    set_in(1'b0, 'x, 'x, 'x);
    tick;
    chk("clr_pre_ovf", bw.out_ovf, 1);
    set_clr(1'b1);
    tick;
    set_clr(1'b0);
    ecw = 0;
    ecc = 0;
    chk_cnt("clr");
    chk("clr_xfer", bw.out_valid, 0);

    // Backpressure: two results buffered, third held off.
    set_rdy(1'b0);
    set_in(1'b1, 32'd10, 32'd0, 32'd0);
    #1;
    chk("bp_rdy0", bw.in_ready, 1);
    tick;
    set_in(1'b1, 32'd20, 32'd0, 32'd0);
    #1;
    chk("bp_rdy1", bw.in_ready, 1);
    tick;
    set_in(1'b1, 32'd30, 32'd0, 32'd0);
    #1;
    chk("bp_rdy2", bw.in_ready, 0);
    chk("bp_sum_a", bw.out_sum, 10);
    tick;
    tick;
    chk("bp_rdy_hold", bw.in_ready, 0);
    chk("bp_sum_hold", bw.out_sum, 10);
    chk("bp_valid_hold", bw.out_valid, 1);
    set_rdy(1'b1);
    #1;
    chk("bp_rdy_comb", bw.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      gv[i]  = bw.out_valid;
      got[i] = bw.out_sum;
      tick;
      if (i == 0) set_in(1'b0, 'x, 'x, 'x);
    end
    chk("bp_out0_v", gv[0], 1);
    chk("bp_out0", got[0], 10);
    chk("bp_out1_v", gv[1], 1);
    chk("bp_out1", got[1], 20);
    chk("bp_out2_v", gv[2], 1);
    chk("bp_out2", got[2], 30);
    chk("bp_out3_v", gv[3], 0);

    // Make the counter nonzero, then reset with both stages full.
    set_in(1'b1, 32'h7FFFFFFF, 32'd1, 32'd0);
    tick;
    set_in(1'b0, 'x, 'x, 'x);
    tick;
    tick;
    ecw = 1;
    ecc = 1;
    chk_cnt("pre_rst");
    set_rdy(1'b0);
    set_in(1'b1, 32'd100, 32'd0, 32'd0);
    tick;
    set_in(1'b1, 32'd200, 32'd0, 32'd0);
    tick;
    set_in(1'b1, 32'd7, 32'd0, 32'd0);
    #1;
    chk("full_in_ready", bw.in_ready, 0);
    rst = 1'b1;
    #1;
    chk("in_rst_in_ready", bw.in_ready, 0);
    tick;
    rst = 1'b0;
    set_in(1'b0, 'x, 'x, 'x);
    #1;
    ecw = 0;
    ecc = 0;
    chk("mid_rst_valid", bw.out_valid, 0);
    chk("mid_rst_in_ready", bw.in_ready, 1);
    chk("mid_rst_sum", bw.out_sum, 0);
    chk_cnt("mid_rst");
    set_rdy(1'b1);
    set_in(1'b1, 32'd4, 32'd5, 32'd6);
    tick;
    set_in(1'b0, 'x, 'x, 'x);
    chk("post_rst_lat1", bw.out_valid, 0);
    tick;
    chk("post_rst_valid", bw.out_valid, 1);
    chk("post_rst_sum", bw.out_sum, 15);
    tick;
    chk("post_rst_drain", bw.out_valid, 0);

    // Idle with undriven operands.
    tick;
    tick;
    chk("idle_valid", bw.out_valid, 0);
    chk("idle_in_ready", bw.in_ready, 1);
    chk_cnt("idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_operand_adder_pipe.md
Name: multi_operand_adder_pipe

Overview:
- Parametrised, pipelined successor to the 3-operand 32-bit combinational adder core.
- Sums NUM_IN signed operands of WIDTH bits each.
- Uses a 2-stage elastic pipeline with valid/ready handshakes on both sides.
- Selectable wrap or saturate result mode, per-result overflow flag and a sticky overflow event counter; sits between HLS-generated datapath blocks.

Parameters:
- WIDTH, 32, operand and result width in bits (8..64).
- NUM_IN, 3, number of operands (2..8).
- SAT_MODE, 0, 0 = two's-complement wrap, 1 = signed saturation.
- CNT_W, 16, overflow counter width.

Ports:
- ap_clk  in  1  clock, all logic rising-edge.
- ap_rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- in_data  in  NUM_IN*WIDTH  packed operands; operand k at bits [k*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result.
- out_ovf  out  1  result overflowed signed WIDTH range.
- ovf_clr  in  1  clear ovf_count.
- ovf_count  out  CNT_W  number of overflowed results accepted downstream, saturating.

Behaviour:
- Internal sum width is SW = WIDTH + clog2(NUM_IN). All operands are sign-extended to SW, so the exact sum never overflows internally.
- Stage 1 (S1) holds register s1_valid plus two partial sums:
  - P0 = operands 0..ceil(NUM_IN/2)-1
  - P1 = the remaining operands
- Stage 2 (S2) holds register s2_valid, out_sum and out_ovf:
  - Computes T = P0 + P1 at SW bits.
  - ovf = T outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - SAT_MODE=0: out_sum = T[WIDTH-1:0].
  - SAT_MODE=1: out_sum is clamped to 2^(WIDTH-1)-1 on positive overflow and to -2^(WIDTH-1) on negative overflow, else T[WIDTH-1:0].
- Handshake:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - out_valid = s2_valid.
  - s2_en = !s2_valid || out_ready. S2 loads from S1 when s2_en; s2_valid <= s1_valid when s2_en.
  - s1_en = !s1_valid || s2_en. in_ready = s1_en, which is combinational from out_ready; this path is accepted.
  - S1 loads when s1_en; s1_valid <= in_valid && in_ready.
  - Data registers hold their value when a stage is not enabled.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid with no backpressure.
  - Throughput is 1 result per cycle; no bubbles while out_ready=1.
  - Up to 2 results are buffered under backpressure; results leave in order, none lost or duplicated.
- out_sum and out_ovf are stable while out_valid && !out_ready.
- Overflow counter:
  - Increments by 1 on each output transfer with out_ovf=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - ovf_clr sets it to 0. ovf_clr wins over a simultaneous increment, so the count is 0 afterwards.
- Reset (any cycle, including mid-flight):
  - s1_valid, s2_valid and out_valid = 0; out_sum = 0; out_ovf = 0; ovf_count = 0.
  - in_ready = 1 in the first cycle after reset is deasserted.
  - In-flight data is discarded; no output transfer is issued for it.
  - While ap_rst=1, in_ready is forced 0 and in_data is ignored.
- in_data is don't-care when in_valid=0. X on in_data when invalid must not propagate to the valid/ready signals or to ovf_count.

Test Plan:
- Defaults, out_ready=1; in_data = {3, 2, 1} -> out_valid exactly 2 cycles after the transfer, out_sum = 6, out_ovf = 0, ovf_count = 0.
- SAT_MODE=0; operands {0, 1, 0x7FFFFFFF} -> out_sum = 0x80000000, out_ovf = 1, ovf_count = 1. Repeat with SAT_MODE=1 -> out_sum = 0x7FFFFFFF, out_ovf = 1.
- SAT_MODE=1; three operands of 0x80000000 -> out_sum = 0x80000000, out_ovf = 1. Operands {-1, -1, 2} -> out_sum = 0, out_ovf = 0.
- Backpressure: hold out_ready=0 and present sums 10, 20, 30 on consecutive cycles -> 10 and 20 accepted, in_ready = 0 on the third cycle, 30 held. Then set out_ready=1 -> outputs 10, 20, 30 in order on consecutive cycles with no duplicates.
- Counter: CNT_W=2, 5 overflowing results -> ovf_count stops at 3. Assert ovf_clr in the same cycle as an overflowing output transfer -> ovf_count = 0.
- Reset: assert ap_rst for 1 cycle with both stages full and out_ready=0 -> next cycle out_valid = 0, in_ready = 1, ovf_count = 0. A new input {4, 5, 6} then yields out_sum = 15 two cycles later.
